// File: rtl/riscy_mem_port_arbiter.sv
// riscy_mem_port_arbiter: shares one OBI-style memory port between the RI5CY fetch and data ports.
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   instr_req/addr_i, instr_gnt/rvalid/rdata_o        fetch port
//   data_req/we/be/addr/wdata_i, data_gnt/rvalid/rdata_o  data port
//   mem_req/we/be/addr/wdata_o, mem_gnt/rvalid/rdata_i  shared memory port
//   busy_o   transactions outstanding
//   error_o  sticky: response arrived with nothing outstanding
module riscy_mem_port_arbiter #(
   parameter int MAX_OUTSTANDING = 2,
   parameter bit DATA_PRIORITY   = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        busy_o,
   output logic        error_o
);
   typedef enum logic {INSTR = 1'b0, DATA = 1'b1} port_e;
   localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wptr_q, rptr_q;
   port_e         fifo_q [MAX_OUTSTANDING];
   port_e         last_q, lock_sel_q, winner, head;
   logic          lock_q, error_q, full, accept, pop, sel_data;
   assign full   = count_q == CW'(MAX_OUTSTANDING);
   // Unlocked ties go to the port that did not win last, unless data is prioritised.
   assign winner = lock_q ? lock_sel_q :
                   (instr_req_i & ~data_req_i) ? INSTR :
                   (data_req_i & ~instr_req_i) ? DATA :
                   (DATA_PRIORITY || last_q == INSTR) ? DATA : INSTR;
   assign sel_data = winner == DATA;
   // Every output is forced low while reset is asserted.
   assign mem_req_o   = rst_ni & (instr_req_i | data_req_i) & ~full;
   assign mem_we_o    = rst_ni & sel_data & data_we_i;
   assign mem_be_o    = {4{rst_ni}} & (sel_data ? data_be_i : 4'hF);
   assign mem_addr_o  = {32{rst_ni}} & (sel_data ? data_addr_i : instr_addr_i);
   assign mem_wdata_o = {32{rst_ni}} & (sel_data ? data_wdata_i : 32'h0);
   assign accept      = mem_req_o & mem_gnt_i;
   assign instr_gnt_o = accept & ~sel_data;
   assign data_gnt_o  = accept & sel_data;
   assign head        = fifo_q[rptr_q];
   assign pop         = rst_ni & mem_rvalid_i & (count_q != '0);
   assign instr_rvalid_o = pop & (head == INSTR);
   assign data_rvalid_o  = pop & (head == DATA);
   assign instr_rdata_o  = {32{rst_ni}} & mem_rdata_i;
   assign data_rdata_o   = {32{rst_ni}} & mem_rdata_i;
   assign busy_o  = count_q != '0;
   assign error_o = error_q;
   assign count_d = count_q + CW'(accept) - CW'(pop);
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q    <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         last_q     <= INSTR;
         lock_q     <= 1'b0;
         lock_sel_q <= INSTR;
         error_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         if (accept) begin
            wptr_q <= wptr_q == PW'(MAX_OUTSTANDING - 1) ? '0 : wptr_q + 1'b1;
            last_q <= winner;
         end
         if (pop) rptr_q <= rptr_q == PW'(MAX_OUTSTANDING - 1) ? '0 : rptr_q + 1'b1;
         // Hold an ungranted request on the same port until the memory accepts it.
         if (accept) lock_q <= 1'b0;
         else if (mem_req_o) begin
            lock_q     <= 1'b1;
            lock_sel_q <= winner;
         end
         if (mem_rvalid_i && count_q == '0) error_q <= 1'b1;
      end
   end
   always_ff @(posedge clk_i) begin
      if (accept) fifo_q[wptr_q] <= winner;
   end
endmodule

// File: tb/tb_riscy_mem_port_arbiter.sv
// tb_riscy_mem_port_arbiter: scoreboard bench for the fetch/data memory arbiter.
module tb_riscy_mem_port_arbiter;
   localparam bit PI = 1'b0, PD = 1'b1;
   logic        clk_i = 1'b0, rst_ni = 1'b0;
   logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
   logic [31:0] instr_addr_i, instr_rdata_o;
   logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
   logic [3:0]  data_be_i, mem_be_o;
   logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
   logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, busy_o, error_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   int checks = 0, failures = 0;
   typedef struct {logic port; logic [31:0] data;} exp_t;
   exp_t sb[$];
   riscy_mem_port_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIORITY(1'b0)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .error_o(error_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", n, act, req);
      end
   endtask
   task automatic nxt;
      @(posedge clk_i);
      #1;
   endtask
   task automatic idle;
      instr_req_i = 0; data_req_i = 0; data_we_i = 0; data_be_i = 0;
      mem_gnt_i = 0; mem_rvalid_i = 0;
   endtask
   task automatic resp(input logic p, input logic [31:0] d);
      mem_rvalid_i = 1;
      mem_rdata_i = d;
      sb.push_back('{p, d});
      nxt();
      mem_rvalid_i = 0;
   endtask
   always @(negedge clk_i) begin : monitor
      exp_t e;
      if (instr_rvalid_o | data_rvalid_o) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rvalid actual=%b%b required=00", instr_rvalid_o, data_rvalid_o);
         end else begin
            e = sb.pop_front();
            chk("rsp_instr_rvalid", 32'(instr_rvalid_o), 32'(e.port == PI));
            chk("rsp_data_rvalid", 32'(data_rvalid_o), 32'(e.port == PD));
            chk("rsp_rdata", e.port ? data_rdata_o : instr_rdata_o, e.data);
         end
      end
   end
   initial begin
      idle();
      instr_addr_i = 0; data_addr_i = 0; data_wdata_i = 0; mem_rdata_i = 0;
      instr_req_i = 1; mem_gnt_i = 1;
      @(negedge clk_i);
      chk("rst_mem_req", 32'(mem_req_o), 0);
      chk("rst_instr_gnt", 32'(instr_gnt_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_error", 32'(error_o), 0);
      nxt();
      idle();
      rst_ni = 1;
      nxt();
      // single fetch
      instr_req_i = 1; instr_addr_i = 32'h80; mem_gnt_i = 1;
      @(negedge clk_i);
      chk("t1_mem_req", 32'(mem_req_o), 1);
      chk("t1_instr_gnt", 32'(instr_gnt_o), 1);
      chk("t1_data_gnt", 32'(data_gnt_o), 0);
      chk("t1_addr", mem_addr_o, 32'h80);
      chk("t1_be", 32'(mem_be_o), 32'hF);
      chk("t1_we", 32'(mem_we_o), 0);
      nxt();
      idle();
      resp(PI, 32'h13);
      // tie after reset-state last grant INSTR: data first, then instr
      instr_req_i = 1; instr_addr_i = 32'h100; data_req_i = 1; data_addr_i = 32'h2000; mem_gnt_i = 1;
      @(negedge clk_i);
      chk("t2_data_gnt", 32'(data_gnt_o), 1);
      chk("t2_instr_gnt0", 32'(instr_gnt_o), 0);
      chk("t2_addr_data", mem_addr_o, 32'h2000);
      nxt();
      @(negedge clk_i);
      chk("t2_instr_gnt", 32'(instr_gnt_o), 1);
      chk("t2_data_gnt0", 32'(data_gnt_o), 0);
      chk("t2_addr_instr", mem_addr_o, 32'h100);
      chk("t2_busy", 32'(busy_o), 1);
      nxt();
      idle();
      resp(PD, 32'hAAAA0001);
      resp(PI, 32'hBBBB0002);
      // make DATA the last winner so an unlocked tie would switch to INSTR
      data_req_i = 1; data_addr_i = 32'h2008; mem_gnt_i = 1;
      @(negedge clk_i);
      chk("t3_prime_gnt", 32'(data_gnt_o), 1);
      nxt();
      data_we_i = 1; data_be_i = 4'b0011; data_addr_i = 32'h3000; data_wdata_i = 32'hDEADBEEF; mem_gnt_i = 0;
      @(negedge clk_i);
      chk("t3_req", 32'(mem_req_o), 1);
      chk("t3_addr0", mem_addr_o, 32'h3000);
      chk("t3_dgnt0", 32'(data_gnt_o), 0);
      nxt();
      instr_req_i = 1; instr_addr_i = 32'h104;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         chk("t3_hold_addr", mem_addr_o, 32'h3000);
         chk("t3_hold_igNT", 32'(instr_gnt_o), 0);
         chk("t3_hold_we", 32'(mem_we_o), 1);
         chk("t3_hold_be", 32'(mem_be_o), 32'h3);
         chk("t3_hold_wdata", mem_wdata_o, 32'hDEADBEEF);
         nxt();
      end
      mem_gnt_i = 1;
      @(negedge clk_i);
      chk("t3_dgnt", 32'(data_gnt_o), 1);
      chk("t3_igNT", 32'(instr_gnt_o), 0);
      chk("t3_addr_gnt", mem_addr_o, 32'h3000);
      nxt();
      data_req_i = 0;
      @(negedge clk_i);
      chk("t3_full_req", 32'(mem_req_o), 0);
      chk("t3_full_igNT", 32'(instr_gnt_o), 0);
      nxt();
      idle();
      resp(PD, 32'h11110000);
      resp(PD, 32'h00000000);
      // outstanding limit
      instr_req_i = 1; instr_addr_i = 32'h200; mem_gnt_i = 1;
      @(negedge clk_i);
      chk("t4_gnt1", 32'(instr_gnt_o), 1);
      nxt();
      instr_addr_i = 32'h204;
      @(negedge clk_i);
      chk("t4_gnt2", 32'(instr_gnt_o), 1);
      nxt();
      instr_addr_i = 32'h208;
      @(negedge clk_i);
      chk("t4_full_req", 32'(mem_req_o), 0);
      chk("t4_full_gnt", 32'(instr_gnt_o), 0);
      chk("t4_busy", 32'(busy_o), 1);
      nxt();
      mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0201;
      sb.push_back('{PI, 32'h0000_0201});
      @(negedge clk_i);
      chk("t4_nobypass_req", 32'(mem_req_o), 0);
      chk("t4_nobypass_gnt", 32'(instr_gnt_o), 0);
      nxt();
      mem_rvalid_i = 0;
      @(negedge clk_i);
      chk("t4_third_req", 32'(mem_req_o), 1);
      chk("t4_third_gnt", 32'(instr_gnt_o), 1);
      chk("t4_third_addr", mem_addr_o, 32'h208);
      nxt();
      idle();
      resp(PI, 32'h0000_0202);
      resp(PI, 32'h0000_0203);
      // spurious response
      mem_rvalid_i = 1; mem_rdata_i = 32'h55;
      @(negedge clk_i);
      chk("t5_err_pre", 32'(error_o), 0);
      nxt();
      mem_rvalid_i = 0;
      @(negedge clk_i);
      chk("t5_err", 32'(error_o), 1);
      chk("t5_busy", 32'(busy_o), 0);
      repeat (3) nxt();
      @(negedge clk_i);
      chk("t5_err_sticky", 32'(error_o), 1);
      nxt();
      // reset with two outstanding
      instr_req_i = 1; instr_addr_i = 32'h300; mem_gnt_i = 1;
      nxt();
      instr_addr_i = 32'h304;
      nxt();
      rst_ni = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h77;
      @(negedge clk_i);
      chk("t6_busy", 32'(busy_o), 0);
      chk("t6_req", 32'(mem_req_o), 0);
      chk("t6_gnt", 32'(instr_gnt_o), 0);
      chk("t6_err", 32'(error_o), 0);
      chk("t6_addr", mem_addr_o, 0);
      chk("t6_be", 32'(mem_be_o), 0);
      chk("t6_rdata", instr_rdata_o, 0);
      nxt();
      idle();
      rst_ni = 1;
      instr_req_i = 1; instr_addr_i = 32'h400; mem_gnt_i = 1;
      @(negedge clk_i);
      chk("t6_post_gnt", 32'(instr_gnt_o), 1);
      chk("t6_post_addr", mem_addr_o, 32'h400);
      nxt();
      idle();
      resp(PI, 32'h99);
      @(negedge clk_i);
      chk("t6_post_busy", 32'(busy_o), 0);
      chk("t6_post_err", 32'(error_o), 0);
      nxt();
      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
